// File: rtl/reg_writeback_queue_pkg.sv
// ---------------------------------------------------------------------------
// reg_writeback_queue_pkg
//   Shared definitions for the register-bank writeback producer.
//   Contents: default result/address widths, the hardwired-zero register
//   address, and the {addr,data} writeback entry carried through the
//   memory-result FIFO.
// ---------------------------------------------------------------------------
package reg_writeback_queue_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  // Register 0 reads as zero, so writes to it are swallowed.
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wbEntry_t;

endpackage

// File: rtl/reg_writeback_queue_wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
//   Small circular FIFO of writeback entries for long-latency memory results.
//   Ports:
//     clk, reset     rising-edge clock, asynchronous active-high reset
//     push/pushEntry write an entry (ignored when full, even if popping)
//     pop            remove the head entry (ignored when empty)
//     headEntry      current head entry (valid when !empty)
//     count          occupied entries, 0..DEPTH
//     full, empty    occupancy flags derived from the current count
//   DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module wb_fifo
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  wbEntry_t               pushEntry,
  input  logic                   pop,
  output wbEntry_t               headEntry,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  wbEntry_t         mem_r [DEPTH];
  logic [PTR_W-1:0] rdPtr_r;
  logic [PTR_W-1:0] wrPtr_r;
  logic [PTR_W:0]   count_r;
  logic             doPush_s;
  logic             doPop_s;

  assign full      = (count_r == (PTR_W+1)'(DEPTH));
  assign empty     = (count_r == {(PTR_W+1){1'b0}});
  assign doPush_s  = push && !full;
  assign doPop_s   = pop && !empty;
  assign headEntry = mem_r[rdPtr_r];
  assign count     = count_r;

  // Storage, pointers and occupancy; contents are cleared on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '{addr: {ADDR_W{1'b0}}, data: {DATA_W{1'b0}}};
      end
      rdPtr_r <= {PTR_W{1'b0}};
      wrPtr_r <= {PTR_W{1'b0}};
      count_r <= {(PTR_W+1){1'b0}};
    end else begin
      if (doPush_s) begin
        mem_r[wrPtr_r] <= pushEntry;
        wrPtr_r        <= wrPtr_r + PTR_W'(1);
      end
      if (doPop_s) begin
        rdPtr_r <= rdPtr_r + PTR_W'(1);
      end
      case ({doPush_s, doPop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// ---------------------------------------------------------------------------
// reg_writeback_queue
//   Write-side producer for the 32x32 register bank. Merges the single-cycle
//   ALU result path and the buffered memory-result path into one registered
//   bank write per cycle. The ALU wins arbitration unless the FIFO head has
//   already lost MAX_WAIT consecutive cycles, in which case the head wins.
//   Ports:
//     clk, reset                   clock, asynchronous active-high reset
//     aluValid/aluAddr/aluData     ALU result offer; aluReady = accepted
//     memValid/memAddr/memData     memory result offer; memReady = FIFO room
//     wrData/wAddr/regWriteFlag    registered bank write port
//     fifoCount                    occupied memory-FIFO entries
//   Optional build macro WB_FWD_EN adds fwdAddr/fwdHit/fwdData so decode can
//   bypass the write the bank is performing this cycle.
//   DATA_W/ADDR_W must match the widths of the shared writeback entry.
// ---------------------------------------------------------------------------
module reg_writeback_queue #(
  parameter int DATA_W   = reg_writeback_queue_pkg::DATA_W,
  parameter int ADDR_W   = reg_writeback_queue_pkg::ADDR_W,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   aluValid,
  output logic                   aluReady,
  input  logic [ADDR_W-1:0]      aluAddr,
  input  logic [DATA_W-1:0]      aluData,
  input  logic                   memValid,
  output logic                   memReady,
  input  logic [ADDR_W-1:0]      memAddr,
  input  logic [DATA_W-1:0]      memData,
  output logic [DATA_W-1:0]      wrData,
  output logic [ADDR_W-1:0]      wAddr,
  output logic                   regWriteFlag,
  output logic [$clog2(DEPTH):0] fifoCount
`ifdef WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0]      fwdAddr,
  output logic                   fwdHit,
  output logic [DATA_W-1:0]      fwdData
`endif
);

  import reg_writeback_queue_pkg::*;

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  wbEntry_t          pushEntry_s;
  wbEntry_t          headEntry_s;
  logic              fifoFull_s;
  logic              fifoEmpty_s;
  logic              memPush_s;
  logic              fifoPop_s;
  logic              starve_s;
  logic              aluWin_s;
  logic [WAIT_W-1:0] waitCnt_r;

  // Arbitration: a head that has waited MAX_WAIT cycles blocks the ALU.
  assign starve_s  = !fifoEmpty_s && (waitCnt_r == WAIT_W'(MAX_WAIT));
  assign aluReady  = !starve_s;
  assign aluWin_s  = aluValid && !starve_s;
  // The head only pops when the ALU did not win, even for an r0 ALU result.
  assign fifoPop_s = !aluWin_s && !fifoEmpty_s;

  // Room is judged on the current count only; r0 results are dropped here.
  assign memReady    = !fifoFull_s;
  assign memPush_s   = memValid && !fifoFull_s && (memAddr != REG_ZERO);
  assign pushEntry_s = '{addr: memAddr, data: memData};

  wb_fifo #(
    .DEPTH (DEPTH)
  ) uFifo (
    .clk       (clk),
    .reset     (reset),
    .push      (memPush_s),
    .pushEntry (pushEntry_s),
    .pop       (fifoPop_s),
    .headEntry (headEntry_s),
    .count     (fifoCount),
    .full      (fifoFull_s),
    .empty     (fifoEmpty_s)
  );

  // Count of consecutive ALU wins over a waiting FIFO head, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waitCnt_r <= {WAIT_W{1'b0}};
    end else if (fifoEmpty_s || fifoPop_s) begin
      waitCnt_r <= {WAIT_W{1'b0}};
    end else if (aluWin_s && (waitCnt_r != WAIT_W'(MAX_WAIT))) begin
      waitCnt_r <= waitCnt_r + WAIT_W'(1);
    end else begin
      waitCnt_r <= waitCnt_r;
    end
  end

  // Bank write register: one-cycle write strobe, address/data hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regWriteFlag <= 1'b0;
      wAddr        <= {ADDR_W{1'b0}};
      wrData       <= {DATA_W{1'b0}};
    end else if (aluWin_s && (aluAddr != REG_ZERO)) begin
      regWriteFlag <= 1'b1;
      wAddr        <= aluAddr;
      wrData       <= aluData;
    end else if (fifoPop_s) begin
      regWriteFlag <= 1'b1;
      wAddr        <= headEntry_s.addr;
      wrData       <= headEntry_s.data;
    end else begin
      regWriteFlag <= 1'b0;
      wAddr        <= wAddr;
      wrData       <= wrData;
    end
  end

`ifdef WB_FWD_EN
  // Same-cycle bypass of the write the bank is absorbing; r0 never hits.
  assign fwdHit  = regWriteFlag && (wAddr == fwdAddr) && (fwdAddr != REG_ZERO);
  assign fwdData = fwdHit ? wrData : {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// ---------------------------------------------------------------------------
// tb_reg_writeback_queue
//   Directed scenarios followed by randomized traffic, checked against a
//   queue-based reference model of the writeback rules.
// ---------------------------------------------------------------------------
module tb_reg_writeback_queue;

  logic        clk;
  logic        reset;
  logic        aluValid;
  logic        aluReady;
  logic [4:0]  aluAddr;
  logic [31:0] aluData;
  logic        memValid;
  logic        memReady;
  logic [4:0]  memAddr;
  logic [31:0] memData;
  logic [31:0] wrData;
  logic [4:0]  wAddr;
  logic        regWriteFlag;
  logic [2:0]  fifoCount;
`ifdef WB_FWD_EN
  logic [4:0]  fwdAddr;
  logic        fwdHit;
  logic [31:0] fwdData;
`endif

  int checks;
  int errors;

  // Reference model state
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;
  ent_t        mQ[$];
  int          mWait;
  logic        mFlag;
  logic [4:0]  mAddr;
  logic [31:0] mData;

  reg_writeback_queue dut (
    .clk          (clk),
    .reset        (reset),
    .aluValid     (aluValid),
    .aluReady     (aluReady),
    .aluAddr      (aluAddr),
    .aluData      (aluData),
    .memValid     (memValid),
    .memReady     (memReady),
    .memAddr      (memAddr),
    .memData      (memData),
    .wrData       (wrData),
    .wAddr        (wAddr),
    .regWriteFlag (regWriteFlag),
    .fifoCount    (fifoCount)
`ifdef WB_FWD_EN
    ,
    .fwdAddr      (fwdAddr),
    .fwdHit       (fwdHit),
    .fwdData      (fwdData)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mQ.delete();
    mWait = 0;
    mFlag = 1'b0;
    mAddr = 5'd0;
    mData = 32'd0;
  endtask

  // One clock: drive inputs after the falling edge, check, then advance model.
  task automatic stepCycle(input logic aV, input logic [4:0] aA, input logic [31:0] aD,
                           input logic mV, input logic [4:0] mA, input logic [31:0] mD);
    bit   nonEmpty;
    bit   starve;
    bit   aluWins;
    bit   popped;
    int   sizeBefore;
    ent_t e;
    @(negedge clk);
    aluValid = aV; aluAddr = aA; aluData = aD;
    memValid = mV; memAddr = mA; memData = mD;
    #1;
    sizeBefore = mQ.size();
    nonEmpty   = (sizeBefore != 0);
    starve     = nonEmpty && (mWait >= 3);
    check("aluReady", 64'(aluReady), 64'(!starve));
    check("memReady", 64'(memReady), 64'(sizeBefore < 4));
    check("fifoCount", 64'(fifoCount), 64'(sizeBefore));
    check("regWriteFlag", 64'(regWriteFlag), 64'(mFlag));
    check("wAddr", 64'(wAddr), 64'(mAddr));
    check("wrData", 64'(wrData), 64'(mData));
    // Outcome of the coming rising edge
    aluWins = aV && !starve;
    popped  = !aluWins && nonEmpty;
    mFlag   = 1'b0;
    if (aluWins && aA != 5'd0) begin
      mFlag = 1'b1; mAddr = aA; mData = aD;
    end else if (popped) begin
      e = mQ.pop_front();
      mFlag = 1'b1; mAddr = e.addr; mData = e.data;
    end
    if (mV && sizeBefore < 4 && mA != 5'd0) begin
      e.addr = mA; e.data = mD;
      mQ.push_back(e);
    end
    if (!nonEmpty || popped) mWait = 0;
    else if (aluWins && mWait < 3) mWait = mWait + 1;
  endtask

  task automatic idle();
    stepCycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    aluValid = 1'b0; aluAddr = 5'd0; aluData = 32'd0;
    memValid = 1'b0; memAddr = 5'd0; memData = 32'd0;
`ifdef WB_FWD_EN
    fwdAddr = 5'd0;
`endif
    modelReset();
    #1;
    check("reset_flag", 64'(regWriteFlag), 64'd0);
    check("reset_wAddr", 64'(wAddr), 64'd0);
    check("reset_wrData", 64'(wrData), 64'd0);
    check("reset_count", 64'(fifoCount), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // ALU only: one-cycle latency
    stepCycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    @(posedge clk); #1;
    check("alu_flag", 64'(regWriteFlag), 64'd1);
    check("alu_wAddr", 64'(wAddr), 64'd5);
    check("alu_wrData", 64'(wrData), 64'hDEADBEEF);
    idle();

    // Memory only: through the FIFO, two cycles
    stepCycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234);
    @(posedge clk); #1;
    check("mem_count1", 64'(fifoCount), 64'd1);
    check("mem_noWriteYet", 64'(regWriteFlag), 64'd0);
    idle();
    @(posedge clk); #1;
    check("mem_flag", 64'(regWriteFlag), 64'd1);
    check("mem_wAddr", 64'(wAddr), 64'd7);
    check("mem_wrData", 64'(wrData), 64'h1234);
    idle();

    // Fill with ALU held valid: head starves after three ALU wins
    for (int i = 0; i < 5; i++) begin
      stepCycle(1'b1, 5'(20 + i), 32'hA000 + 32'(i), 1'b1, 5'(10 + i), 32'hB000 + 32'(i));
      if (i == 4) begin
        check("fill_memReady", 64'(memReady), 64'd0);
        check("fill_count", 64'(fifoCount), 64'd4);
        check("starve_aluReady", 64'(aluReady), 64'd0);
      end
    end
    @(posedge clk); #1;
    check("starve_flag", 64'(regWriteFlag), 64'd1);
    check("starve_wAddr", 64'(wAddr), 64'd10);
    check("starve_wrData", 64'(wrData), 64'hB000);
    stepCycle(1'b1, 5'd25, 32'hA005, 1'b0, 5'd0, 32'd0);
    check("starve_released", 64'(aluReady), 64'd1);
    repeat (6) idle();

    // Register 0 results are consumed but never written or queued
    stepCycle(1'b1, 5'd0, 32'hFFFF0000, 1'b1, 5'd0, 32'h0000FFFF);
    @(posedge clk); #1;
    check("zero_flag", 64'(regWriteFlag), 64'd0);
    check("zero_count", 64'(fifoCount), 64'd0);
    idle();

    // Reset mid-operation with three queued entries and a write pending
    for (int i = 0; i < 3; i++) begin
      stepCycle(1'b1, 5'(1 + i), 32'hC000 + 32'(i), 1'b1, 5'(4 + i), 32'hD000 + 32'(i));
    end
    @(posedge clk); #1;
    check("pre_reset_count", 64'(fifoCount), 64'd3);
    check("pre_reset_flag", 64'(regWriteFlag), 64'd1);
    aluValid = 1'b0; memValid = 1'b0;
    reset = 1'b1;
    #1;
    check("async_reset_flag", 64'(regWriteFlag), 64'd0);
    check("async_reset_count", 64'(fifoCount), 64'd0);
    modelReset();
    #1;
    reset = 1'b0;
    repeat (4) idle();

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      stepCycle(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0, 5'($urandom_range(0, 31)), $urandom(),
                ($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0, 5'($urandom_range(0, 31)), $urandom());
    end
    repeat (8) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
